memory_access: RTL and testbench

- Memory stage of the RISC-V pipeline; consumes the EX/MEM pipeline register outputs of the execution stage.
- Performs loads and stores on a req/ready data-memory bus: byte-lane generation, load sign/zero extension, misalignment detection.
- Stalls upstream while a bus access is outstanding and registers results into the MEM/WB register.

---
 rtl/memory_access.sv | 278 +++++++++++++++++++++++++++
 tb/tb_memory_access.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// memory_access
// RV32 memory stage. Decodes the EX/MEM instruction, issues loads and stores
// on a req/ready data bus, extends load data and registers the MEM/WB fields.
// A legal aligned access is issued from IDLE. The stage then waits in REQ until
// the slave answers, and o_mem_stall freezes the upstream stages meanwhile.
//
// Optional build macro: MEM_BUS_TIMEOUT_EN
//   When this macro is defined, a REQ that receives no ready within
//   TIMEOUT_CYCLES enabled cycles is aborted, and the instruction leaves the
//   stage with o_mem_bus_err set. When it is undefined, REQ waits forever and
//   o_mem_bus_err stays 0.
//
// Ports
//   clk, rst_n, clk_en          clock, synchronous active-low reset, clock enable
//   i_ex_*                      EX/MEM pipeline register outputs
//   o_dmem_*, i_dmem_*          data-memory bus (word-aligned address, byte enables)
//   o_mem_stall                 combinational freeze of EX/MEM and upstream
//   o_mem_*                     MEM/WB pipeline register outputs
//
// State table
//   state    | meaning
//   ST_IDLE  | no access outstanding; the EX/MEM instruction is decoded every cycle
//   ST_REQ   | request issued; bus outputs frozen; waiting for i_dmem_ready

module memory_access #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    input  logic                      i_ex_mem_to_reg,
    input  logic                      i_ex_reg_wr,
    input  logic                      i_ex_mem_rd,
    input  logic                      i_ex_mem_wr,
    input  logic                      i_ex_result_src,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_reg_destination,
    input  logic [2:0]                i_ex_funct3,
    input  logic [DATA_WIDTH-1:0]     i_ex_pc_plus_4,
    input  logic [DATA_WIDTH-1:0]     i_ex_alu_result,
    input  logic [DATA_WIDTH-1:0]     i_ex_data2,
    output logic                      o_dmem_req,
    output logic                      o_dmem_we,
    output logic [DATA_WIDTH-1:0]     o_dmem_addr,
    output logic [DATA_WIDTH-1:0]     o_dmem_wdata,
    output logic [3:0]                o_dmem_be,
    input  logic                      i_dmem_ready,
    input  logic [DATA_WIDTH-1:0]     i_dmem_rdata,
    output logic                      o_mem_stall,
    output logic                      o_mem_mem_to_reg,
    output logic                      o_mem_reg_wr,
    output logic                      o_mem_result_src,
    output logic [REG_ADDR_WIDTH-1:0] o_mem_reg_destination,
    output logic [DATA_WIDTH-1:0]     o_mem_read_data,
    output logic [DATA_WIDTH-1:0]     o_mem_alu_result,
    output logic [DATA_WIDTH-1:0]     o_mem_pc_plus_4,
    output logic                      o_mem_misaligned,
    output logic                      o_mem_bus_err
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic                  mem_op;
    logic                  is_store;
    logic                  size_legal;
    logic                  aligned;
    logic                  access;
    logic                  bad_access;
    logic [1:0]            addr_lo;
    logic [3:0]            be_calc;
    logic [DATA_WIDTH-1:0] wdata_calc;

    logic                  bus_timeout;
    logic                  mem_stall;

    logic [1:0]            lane_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH-1:0] load_ext;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign mem_op   = i_ex_mem_rd | i_ex_mem_wr;
    assign is_store = i_ex_mem_wr;
    assign addr_lo  = i_ex_alu_result[1:0];

    always_comb begin
        size_legal = 1'b0;
        aligned    = 1'b1;
        be_calc    = 4'b0000;
        wdata_calc = i_ex_data2;
        case (i_ex_funct3)
            F3_B, F3_BU: begin
                // A store has no unsigned form, so BU is legal only for a load.
                size_legal = !(is_store && (i_ex_funct3 == F3_BU));
                be_calc    = 4'b0001 << addr_lo;
                wdata_calc = {4{i_ex_data2[7:0]}};
            end
            F3_H, F3_HU: begin
                size_legal = !(is_store && (i_ex_funct3 == F3_HU));
                aligned    = !addr_lo[0];
                be_calc    = 4'b0011 << addr_lo;
                wdata_calc = {2{i_ex_data2[15:0]}};
            end
            F3_W: begin
                size_legal = 1'b1;
                aligned    = (addr_lo == 2'b00);
                be_calc    = 4'b1111;
            end
            default: ;
        endcase
    end

    assign access     = mem_op & size_legal & aligned;
    assign bad_access = mem_op & !(size_legal & aligned);

    // ------------------------------------------------------------------
    // Optional bus timeout
    // ------------------------------------------------------------------
`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] req_cnt;

    // The count is held at zero in IDLE, so it is cleared when REQ is entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_cnt <= '0;
        end else if (clk_en) begin
            if (state == ST_IDLE) begin
                req_cnt <= '0;
            end else begin
                req_cnt <= req_cnt + CNT_W'(1);
            end
        end
    end

    // The abort fires in the last allowed REQ cycle. Stall drops in that same
    // cycle, so the instruction leaves the stage with the error flag.
    assign bus_timeout = (state == ST_REQ) && !i_dmem_ready &&
                         (req_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic timeout_cfg_unused;
    assign timeout_cfg_unused = (TIMEOUT_CYCLES > 0);
    assign bus_timeout        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        case (state)
            ST_IDLE: begin
                mem_stall = access;
                if (access) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_stall = !i_dmem_ready && !bus_timeout;
                if (i_dmem_ready || bus_timeout) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_mem_stall = mem_stall;

    // ------------------------------------------------------------------
    // Bus request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            o_dmem_be    <= 4'b0000;
            lane_q       <= 2'b00;
            funct3_q     <= 3'b000;
        end else if (clk_en) begin
            if ((state == ST_IDLE) && access) begin
                o_dmem_req   <= 1'b1;
                o_dmem_we    <= is_store;
                o_dmem_addr  <= {i_ex_alu_result[DATA_WIDTH-1:2], 2'b00};
                o_dmem_wdata <= wdata_calc;
                o_dmem_be    <= be_calc;
                lane_q       <= addr_lo;
                funct3_q     <= i_ex_funct3;
            end else if ((state == ST_REQ) && (i_dmem_ready || bus_timeout)) begin
                o_dmem_req <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extension. The lane and size come from the latched request,
    // so the result does not depend on the held EX inputs.
    // ------------------------------------------------------------------
    always_comb begin
        lane_data = i_dmem_rdata >> {lane_q, 3'b000};
        load_ext  = lane_data;
        case (funct3_q)
            F3_B:    load_ext = {{(DATA_WIDTH-8){lane_data[7]}}, lane_data[7:0]};
            F3_BU:   load_ext = {{(DATA_WIDTH-8){1'b0}}, lane_data[7:0]};
            F3_H:    load_ext = {{(DATA_WIDTH-16){lane_data[15]}}, lane_data[15:0]};
            F3_HU:   load_ext = {{(DATA_WIDTH-16){1'b0}}, lane_data[15:0]};
            default: load_ext = lane_data;
        endcase
    end

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_mem_mem_to_reg      <= 1'b0;
            o_mem_reg_wr          <= 1'b0;
            o_mem_result_src      <= 1'b0;
            o_mem_reg_destination <= '0;
            o_mem_read_data       <= '0;
            o_mem_alu_result      <= '0;
            o_mem_pc_plus_4       <= '0;
            o_mem_misaligned      <= 1'b0;
            o_mem_bus_err         <= 1'b0;
        end else if (clk_en) begin
            if (mem_stall) begin
                // Bubble: kill the write and the flags and keep the data fields.
                o_mem_reg_wr     <= 1'b0;
                o_mem_misaligned <= 1'b0;
                o_mem_bus_err    <= 1'b0;
            end else begin
                o_mem_mem_to_reg      <= i_ex_mem_to_reg;
                o_mem_result_src      <= i_ex_result_src;
                o_mem_reg_destination <= i_ex_reg_destination;
                o_mem_alu_result      <= i_ex_alu_result;
                o_mem_pc_plus_4       <= i_ex_pc_plus_4;
                o_mem_reg_wr          <= i_ex_reg_wr & !bad_access & !bus_timeout;
                o_mem_misaligned      <= bad_access;
                o_mem_bus_err         <= bus_timeout;
                if ((state == ST_REQ) && i_dmem_ready && !o_dmem_we) begin
                    o_mem_read_data <= load_ext;
                end else begin
                    o_mem_read_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        ex_mem_to_reg, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_result_src;
    logic [4:0]  ex_reg_destination;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc_plus_4, ex_alu_result, ex_data2;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        mem_mem_to_reg, mem_reg_wr, mem_result_src;
    logic [4:0]  mem_reg_destination;
    logic [31:0] mem_read_data, mem_alu_result, mem_pc_plus_4;
    logic        mem_misaligned, mem_bus_err;

    memory_access #(
        .DATA_WIDTH(32),
        .REG_ADDR_WIDTH(5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_en(clk_en),
        .i_ex_mem_to_reg(ex_mem_to_reg),
        .i_ex_reg_wr(ex_reg_wr),
        .i_ex_mem_rd(ex_mem_rd),
        .i_ex_mem_wr(ex_mem_wr),
        .i_ex_result_src(ex_result_src),
        .i_ex_reg_destination(ex_reg_destination),
        .i_ex_funct3(ex_funct3),
        .i_ex_pc_plus_4(ex_pc_plus_4),
        .i_ex_alu_result(ex_alu_result),
        .i_ex_data2(ex_data2),
        .o_dmem_req(dmem_req),
        .o_dmem_we(dmem_we),
        .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata),
        .o_dmem_be(dmem_be),
        .i_dmem_ready(dmem_ready),
        .i_dmem_rdata(dmem_rdata),
        .o_mem_stall(mem_stall),
        .o_mem_mem_to_reg(mem_mem_to_reg),
        .o_mem_reg_wr(mem_reg_wr),
        .o_mem_result_src(mem_result_src),
        .o_mem_reg_destination(mem_reg_destination),
        .o_mem_read_data(mem_read_data),
        .o_mem_alu_result(mem_alu_result),
        .o_mem_pc_plus_4(mem_pc_plus_4),
        .o_mem_misaligned(mem_misaligned),
        .o_mem_bus_err(mem_bus_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (size/sign arithmetic) ----------------
    function automatic int unsigned acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit f3_legal(input bit store, input logic [2:0] f3);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if (store && f3[2]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned sz, bits;
        logic [31:0] v, mask;
        sz = acc_size(f3);
        v  = rdata >> (8 * (addr % 4));
        if (sz == 4) return v;
        bits = 8 * sz;
        mask = (32'd1 << bits) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic clear_ex();
        ex_mem_to_reg = 0; ex_reg_wr = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_result_src = 0;
        ex_reg_destination = 0; ex_funct3 = 0; ex_pc_plus_4 = 0; ex_alu_result = 0; ex_data2 = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, dmem_req, 0);
        chk({tag, "_we"}, dmem_we, 0);
        chk({tag, "_addr"}, dmem_addr, 0);
        chk({tag, "_wdata"}, dmem_wdata, 0);
        chk({tag, "_be"}, dmem_be, 0);
        chk({tag, "_stall"}, mem_stall, 0);
        chk({tag, "_wb_m2r"}, mem_mem_to_reg, 0);
        chk({tag, "_wb_regwr"}, mem_reg_wr, 0);
        chk({tag, "_wb_rsrc"}, mem_result_src, 0);
        chk({tag, "_wb_rd"}, mem_reg_destination, 0);
        chk({tag, "_wb_rdata"}, mem_read_data, 0);
        chk({tag, "_wb_alu"}, mem_alu_result, 0);
        chk({tag, "_wb_pc4"}, mem_pc_plus_4, 0);
        chk({tag, "_wb_mis"}, mem_misaligned, 0);
        chk({tag, "_wb_berr"}, mem_bus_err, 0);
    endtask

    // One instruction through the stage, the slave answering after `delay`
    // enabled wait cycles; with rand_en the clock enable toggles while waiting.
    task automatic run_instr(input bit rd_i, input bit wr_i, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] d2,
                             input logic [31:0] rdata, input int delay,
                             input bit rand_en, input bit reg_wr_i);
        bit store, acc, bad, done;
        int unsigned sz, bem;
        int waited, budget;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_addr;
        logic        m2r, rsrc;
        logic [4:0]  rdst;
        logic [31:0] pc4;
        m2r  = 1'($urandom_range(0, 1));
        rsrc = 1'($urandom_range(0, 1));
        rdst = 5'($urandom);
        pc4  = $urandom;
        store = wr_i;
        sz    = acc_size(f3);
        acc   = (rd_i || wr_i) && f3_legal(store, f3) && ((addr % sz) == 0);
        bad   = (rd_i || wr_i) && !acc;
        bem   = ((32'd1 << sz) - 1) << (addr % 4);
        exp_be = bem[3:0];
        exp_addr = {addr[31:2], 2'b00};
        exp_wd = '0;
        for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = 8'(d2 >> (8 * (k % sz)));

        ex_mem_rd = rd_i; ex_mem_wr = wr_i; ex_funct3 = f3; ex_alu_result = addr;
        ex_data2 = d2; ex_reg_wr = reg_wr_i; ex_mem_to_reg = m2r; ex_result_src = rsrc;
        ex_reg_destination = rdst; ex_pc_plus_4 = pc4;
        clk_en = 1; dmem_ready = 0;
        #1;
        chk("stall_issue", mem_stall, acc);
        chk("req_idle", dmem_req, 0);
        tick();
        if (acc) begin
            chk("bubble_regwr", mem_reg_wr, 0);
            chk("bubble_mis", mem_misaligned, 0);
            chk("req_up", dmem_req, 1);
            chk("we", dmem_we, store);
            chk("addr", dmem_addr, exp_addr);
            chk("be", dmem_be, exp_be);
            if (store) chk("wdata", dmem_wdata, exp_wd);
            waited = 0; done = 0; budget = 0;
            while (!done && budget < 64) begin
                clk_en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (waited >= delay) begin
                    dmem_ready = 1;
                    dmem_rdata = rdata;
                end
                #1;
                chk("stall_req", mem_stall, !dmem_ready);
                tick();
                if (dmem_ready && clk_en) begin
                    done = 1;
                end else begin
                    if (clk_en) waited++;
                    chk("req_hold", dmem_req, 1);
                    chk("addr_hold", dmem_addr, exp_addr);
                    chk("be_hold", dmem_be, exp_be);
                    chk("wait_regwr", mem_reg_wr, 0);
                end
                budget++;
            end
            if (!done) chk("req_budget", 0, 1);
            chk("req_drop", dmem_req, 0);
            chk("wb_rdata", mem_read_data, store ? 32'h0 : load_val(f3, addr, rdata));
            chk("wb_mis", mem_misaligned, 0);
            dmem_ready = 0;
        end else begin
            chk("req_none", dmem_req, 0);
            chk("wb_mis", mem_misaligned, bad);
            chk("wb_rdata", mem_read_data, 0);
        end
        chk("wb_regwr", mem_reg_wr, reg_wr_i && !bad);
        chk("wb_berr", mem_bus_err, 0);
        chk("wb_rd", mem_reg_destination, rdst);
        chk("wb_alu", mem_alu_result, addr);
        chk("wb_pc4", mem_pc_plus_4, pc4);
        chk("wb_m2r", mem_mem_to_reg, m2r);
        chk("wb_rsrc", mem_result_src, rsrc);
        clk_en = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] legal_f3 [5];
        logic [2:0] f3;
        int sel;
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

        rst_n = 0; clk_en = 1; dmem_ready = 0; dmem_rdata = 0;
        clear_ex();
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1;

        // Directed cases
        run_instr(1, 0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 0, 0, 1);   // LW
        run_instr(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1);   // LB
        run_instr(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1);   // LBU
        run_instr(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 0, 0, 1);   // LHU
        run_instr(0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 0, 0, 0);   // SB
        run_instr(0, 1, 3'b010, 32'h202, 32'h12345678, 32'h0, 0, 0, 0);   // SW misaligned
        run_instr(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1);          // illegal size
        run_instr(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 0);          // unsigned store
        run_instr(0, 0, 3'b010, 32'h7, 32'h0, 32'h0, 0, 0, 1);            // ALU op
        run_instr(1, 0, 3'b001, 32'h306, 32'h0, 32'h8001ABCD, 3, 1, 1);   // LH, slow, clk_en toggling
        run_instr(1, 1, 3'b001, 32'h10, 32'hA5A5C3C3, 32'h0, 2, 0, 1);    // rd+wr: store wins

        // Reset in the middle of a request
        ex_mem_rd = 1; ex_funct3 = 3'b010; ex_alu_result = 32'h300; ex_reg_wr = 1;
        clk_en = 1; dmem_ready = 0;
        tick();
        chk("rst_req_up", dmem_req, 1);
        clk_en = 0;
        tick();
        chk("rst_req_hold_en0", dmem_req, 1);
        clk_en = 1;
        tick();
        chk("rst_req_hold", dmem_req, 1);
        rst_n = 0; clk_en = 0; clear_ex();
        dmem_ready = 1; dmem_rdata = 32'hCAFEF00D;
        tick();
        chk_all_zero("rst_mid");
        rst_n = 1; clk_en = 1; dmem_ready = 0;
        tick();
        chk("post_rst_req", dmem_req, 0);
        chk("post_rst_rdata", mem_read_data, 0);

        // Slave that never answers
        ex_mem_rd = 1; ex_funct3 = 3'b010; ex_alu_result = 32'h400; ex_reg_wr = 1;
        clk_en = 1; dmem_ready = 0;
        tick();
        chk("to_req_up", dmem_req, 1);
`ifdef MEM_BUS_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            #1;
            chk("to_stall", mem_stall, (i < TO - 1));
            tick();
            if (i < TO - 1) begin
                chk("to_req_hold", dmem_req, 1);
            end else begin
                chk("to_req_drop", dmem_req, 0);
                chk("to_berr", mem_bus_err, 1);
                chk("to_regwr", mem_reg_wr, 0);
            end
        end
        clear_ex();
        tick();
        chk("to_berr_clear", mem_bus_err, 0);
`else
        for (int i = 0; i < 30; i++) begin
            #1;
            chk("hang_stall", mem_stall, 1);
            tick();
            chk("hang_req", dmem_req, 1);
            chk("hang_berr", mem_bus_err, 0);
        end
        rst_n = 0; clear_ex();
        tick();
        rst_n = 1;
        tick();
`endif

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) f3 = legal_f3[$urandom_range(0, 4)];
            else f3 = 3'($urandom);
            run_instr(sel == 1 || sel == 3, sel == 2 || sel == 3, f3, $urandom, $urandom,
                      $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
